// File: rtl/seg7_reader_if.sv
// Character-side bus of seg7_reader: head-of-queue code with a valid/ready
// handshake plus queue status. The master modport belongs to the reader and the
// slave modport belongs to the consumer.
interface seg7_reader_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

    logic [4:0]        char_code;
    logic              char_valid;
    logic              char_ready;
    logic [LevelW-1:0] fifo_level;
    logic [7:0]        char_count;
    logic              overflow;

    modport master (
        output char_code,
        output char_valid,
        input  char_ready,
        output fifo_level,
        output char_count,
        output overflow
    );

    modport slave (
        input  char_code,
        input  char_valid,
        output char_ready,
        input  fifo_level,
        input  char_count,
        input  overflow
    );
endinterface

// File: rtl/seg7_reader.sv
// seg7_reader: watches a 7-segment bus and waits for a pattern to hold steady
// for STABLE_CYCLES samples. It then decodes the pattern to a 5-bit character
// code and queues it for a valid/ready consumer.
// Optional build macro SEG7_READER_ACTIVE_LOW_EN: when it is defined, seg_in is
// treated as common-anode (active-low) and inverted before sampling.
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [6:0]    seg_in,
    seg7_reader_if.master char_if
);
    localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned PtrW   = AddrW + 1;
    localparam logic [7:0]  RunMax = 8'(STABLE_CYCLES);

    logic [6:0] seg_eff;

`ifdef SEG7_READER_ACTIVE_LOW_EN
    assign seg_eff = ~seg_in;
`else
    assign seg_eff = seg_in;
`endif

    logic [6:0]      samp_q, samp_d;
    logic [7:0]      run_q, run_d;
    logic            armed_q, armed_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]      count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [4:0]      mem_q [FIFO_DEPTH];

    logic            accept;
    logic            empty;
    logic            full;
    logic            deq;
    logic            enq;
    logic [4:0]      code;

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F: decode = 5'd0;
            7'h06: decode = 5'd1;
            7'h5B: decode = 5'd2;
            7'h4F: decode = 5'd3;
            7'h66: decode = 5'd4;
            7'h6D: decode = 5'd5;
            7'h7D: decode = 5'd6;
            7'h07: decode = 5'd7;
            7'h7F: decode = 5'd8;
            7'h6F: decode = 5'd9;
            7'h77: decode = 5'd10;
            7'h7C: decode = 5'd11;
            7'h39: decode = 5'd12;
            7'h5E: decode = 5'd13;
            7'h79: decode = 5'd14;
            7'h71: decode = 5'd15;
            7'h3D: decode = 5'd16;
            7'h76: decode = 5'd17;
            7'h38: decode = 5'd18;
            7'h73: decode = 5'd19;
            7'h3E: decode = 5'd20;
            7'h6E: decode = 5'd21;
            7'h50: decode = 5'd22;
            7'h5C: decode = 5'd23;
            default: decode = 5'd31;
        endcase
    endfunction

    // Accept/queue decisions and next-state for sampler, pointers and status.
    always_comb begin
        code   = decode(samp_q);
        accept = (run_q == RunMax) && armed_q && (samp_q != 7'h00);
        empty  = (wr_ptr_q == rd_ptr_q);
        // Full when the pointers differ only in their wrap bit.
        full   = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                 (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
        deq    = !empty && char_if.char_ready;
        enq    = accept && (!full || deq);

        samp_d   = samp_q;
        run_d    = run_q;
        armed_d  = armed_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (accept) begin
            armed_d = 1'b0;
        end
        // A new pattern restarts the run and re-arms, even on an accept edge.
        if (seg_eff != samp_q) begin
            samp_d  = seg_eff;
            run_d   = 8'd1;
            armed_d = 1'b1;
        end else if (run_q != RunMax) begin
            run_d = run_q + 8'd1;
        end

        if (enq) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
            count_d  = count_q + 8'd1;
        end else if (accept) begin
            ovf_d = 1'b1;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    // Control state, with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            samp_q   <= 7'h00;
            run_q    <= 8'd0;
            armed_q  <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 8'd0;
            ovf_q    <= 1'b0;
        end else begin
            samp_q   <= samp_d;
            run_q    <= run_d;
            armed_q  <= armed_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Queue storage; contents are don't-care while the queue is empty.
    always_ff @(posedge clk) begin
        if (rst_n && enq) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= code;
        end
    end

    // Head-of-queue and status outputs.
    always_comb begin
        char_if.char_valid = !empty;
        char_if.char_code  = empty ? 5'd0 : mem_q[rd_ptr_q[AddrW-1:0]];
        char_if.fifo_level = wr_ptr_q - rd_ptr_q;
        char_if.char_count = count_q;
        char_if.overflow   = ovf_q;
    end
endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader. The model accepts a character on the edge that follows
// S consecutive sampled edges of the same nonzero pattern, when the pattern
// before that run differed. It then queues the expected code. The monitor pops
// the expected codes on handshakes and compares the status outputs every cycle.
module tb_seg7_reader;
    localparam int unsigned S = 4;
    localparam int unsigned D = 4;

    localparam logic [6:0] PATS [24] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
        7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h3D, 7'h76, 7'h38, 7'h73,
        7'h3E, 7'h6E, 7'h50, 7'h5C
    };

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] pat;
    logic [6:0] seg_in;
    logic       rdy;

    always #5 clk = ~clk;

`ifdef SEG7_READER_ACTIVE_LOW_EN
    assign seg_in = ~pat;
`else
    assign seg_in = pat;
`endif

    seg7_reader_if #(.FIFO_DEPTH(D)) char_if ();
    assign char_if.char_ready = rdy;

    seg7_reader #(
        .STABLE_CYCLES(S),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seg_in (seg_in),
        .char_if(char_if)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int code_of(input logic [6:0] p);
        for (int i = 0; i < 24; i++) if (PATS[i] == p) return i;
        return 31;
    endfunction

    // Reference model state.
    int         exp_q [$];
    logic [6:0] hist [$];
    int         m_lvl;
    int         m_cnt;
    int         m_ovf;

    // Model: decides enqueue/dequeue at each edge from the bench's own stimulus.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                hist.delete();
                for (int i = 0; i <= S; i++) hist.push_back(7'h00);
                m_lvl = 0;
                m_cnt = 0;
                m_ovf = 0;
                exp_q.delete();
            end else begin
                logic [6:0] p;
                bit         en;
                bit         dq;
                p  = hist[S];
                en = (p != 7'h00) && (hist[0] != p);
                for (int i = 1; i <= S; i++) if (hist[i] != p) en = 0;
                dq = rdy && (m_lvl > 0);
                if (en) begin
                    if (m_lvl < D || dq) begin
                        exp_q.push_back(code_of(p));
                        m_cnt = (m_cnt + 1) % 256;
                        m_lvl++;
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (dq) m_lvl--;
                void'(hist.pop_front());
                hist.push_back(pat);
            end
        end
    end

    // Monitor: status every cycle, and code on each handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("valid", int'(char_if.char_valid), int'(m_lvl > 0));
                check("level", int'(char_if.fifo_level), m_lvl);
                check("count", int'(char_if.char_count), m_cnt);
                check("overflow", int'(char_if.overflow), m_ovf);
                if (char_if.char_valid && rdy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_char", int'(char_if.char_code), -1);
                    end else begin
                        check("code", int'(char_if.char_code), exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        pat = p;
        step(n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        pat   = 7'h00;
        rdy   = 1'b0;
        step(2);
        rst_n = 1'b1;
        check("rst_valid", int'(char_if.char_valid), 0);
        check("rst_code", int'(char_if.char_code), 0);
        check("rst_level", int'(char_if.fifo_level), 0);
        check("rst_count", int'(char_if.char_count), 0);
        check("rst_overflow", int'(char_if.overflow), 0);

        // Single steady character: accepted on the fifth edge.
        hold(7'h3F, 4);
        check("t1_not_yet", int'(char_if.char_valid), 0);
        step(1);
        check("t1_valid", int'(char_if.char_valid), 1);
        check("t1_code", int'(char_if.char_code), 0);
        step(5);
        check("t1_level", int'(char_if.fifo_level), 1);
        check("t1_count", int'(char_if.char_count), 1);
        pat = 7'h00;
        rdy = 1'b1;
        step(1);
        rdy = 1'b0;
        step(S + 1);

        // Repeats separated by blanks.
        hold(7'h06, 6);
        hold(7'h00, 6);
        hold(7'h06, 6);
        hold(7'h00, 6);
        hold(7'h5B, 6);
        hold(7'h00, 2);
        check("t2_level", int'(char_if.fifo_level), 3);
        rdy = 1'b1;
        step(4);
        rdy = 1'b0;
        check("t2_drained", int'(char_if.fifo_level), 0);
        check("t2_count", int'(char_if.char_count), 4);

        // A glitch shorter than S produces nothing.
        hold(7'h3F, 3);
        hold(7'h00, 6);
        check("t3_level", int'(char_if.fifo_level), 0);
        check("t3_count", int'(char_if.char_count), 4);

        // Overflow, then enqueue while full with a simultaneous dequeue.
        do_reset();
        hold(7'h77, 5);
        hold(7'h7C, 5);
        hold(7'h39, 5);
        hold(7'h5E, 5);
        hold(7'h79, 5);
        hold(7'h00, 5);
        check("t4_level", int'(char_if.fifo_level), 4);
        check("t4_overflow", int'(char_if.overflow), 1);
        check("t4_count", int'(char_if.char_count), 4);
        pat = 7'h79;
        step(S);
        rdy = 1'b1;
        step(1);
        rdy = 1'b0;
        check("t4_full_swap_level", int'(char_if.fifo_level), 4);
        check("t4_full_swap_count", int'(char_if.char_count), 5);
        hold(7'h00, S + 1);
        rdy = 1'b1;
        step(5);
        rdy = 1'b0;
        check("t4_drained", int'(char_if.fifo_level), 0);

        // Unknown pattern decodes to 31; then reset with two entries queued.
        hold(7'h49, 4);
        hold(7'h00, 2);
        rdy = 1'b1;
        step(1);
        rdy = 1'b0;
        hold(7'h06, 5);
        hold(7'h00, 2);
        hold(7'h5B, 5);
        hold(7'h00, 2);
        check("t5_level", int'(char_if.fifo_level), 2);
        pat = 7'h3F;
        do_reset();
        pat = 7'h00;
        check("t5_valid", int'(char_if.char_valid), 0);
        check("t5_level_rst", int'(char_if.fifo_level), 0);
        check("t5_overflow", int'(char_if.overflow), 0);
        check("t5_count", int'(char_if.char_count), 0);
        step(S + 1);

        // Letter A through the pin polarity of this build.
        hold(7'h77, 4);
        hold(7'h00, 2);
        check("t6_level", int'(char_if.fifo_level), 1);
        rdy = 1'b1;
        step(1);
        rdy = 1'b0;

        // Randomised patterns and hold lengths; the consumer is ready at least
        // every other cycle, so the queue can never fill.
        for (int h = 0; h < 120; h++) begin
            int         r;
            int         len;
            logic [6:0] p;
            r = $urandom_range(0, 29);
            if (r < 24) p = PATS[r];
            else if (r < 27) p = 7'h00;
            else p = 7'($urandom);
            len = $urandom_range(1, 2 * S + 2);
            for (int c = 0; c < len; c++) begin
                rdy = (c % 2 == 1) || ($urandom_range(0, 1) == 1);
                pat = p;
                step(1);
            end
        end

        pat = 7'h00;
        rdy = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step(1);
        step(S + 2);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_valid", int'(char_if.char_valid), 0);
        rdy = 1'b0;
        step(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/seg7_reader.md
Name: seg7_reader

Overview:
Decodes a 7-segment display bus back into character codes; it is the receive-side counterpart of the segment driver. It watches a segment pattern on an input port and waits until that pattern has held steady for a programmable number of cycles. It then decodes the pattern to a 5-bit character code and queues it in a small FIFO. Downstream logic drains the FIFO with a valid/ready handshake. Used for loopback self-test of the display path and for reading an external display.

Parameters:
STABLE_CYCLES, 4, consecutive sampled cycles a pattern must hold before it is accepted; legal 1..255.
FIFO_DEPTH, 4, character queue entries; power of two, 2..16.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
seg_in  input  7  segment pattern; bit0=a … bit6=g, active-high
char_code  output  5  head-of-FIFO character code
char_valid  output  1  FIFO non-empty; char_code is meaningful
char_ready  input  1  consumer accepts head when char_valid&char_ready at clk edge
fifo_level  output  clog2(FIFO_DEPTH)+1  entries currently queued
char_count  output  8  total characters enqueued since reset, wraps 255->0
overflow  output  1  sticky: a character was dropped because FIFO was full

Behaviour:
- Reset (rst_n low at clk edge). Clears samp to 7'h00, run to 0, armed to 1, and the FIFO to empty. Outputs: char_valid=0, char_code=0, fifo_level=0, char_count=0, overflow=0. Reset takes priority over all other activity, including a handshake or enqueue in the same cycle.
- Sampler and stability counter:
  - samp register captures seg_in each edge.
  - If seg_in != samp at an edge: samp<=seg_in, run<=1, armed<=1.
  - Otherwise run<=run+1, saturating at STABLE_CYCLES.
- Accept event: when run==STABLE_CYCLES, armed==1 and samp!=7'h00, one enqueue is issued at that edge and armed<=0. Each steady run produces exactly one character.
  - Repeating a character requires an intervening different pattern, normally blank.
  - A blank pattern (7'h00) is a separator and is never enqueued.
  - A pattern held fewer than STABLE_CYCLES cycles produces nothing.
- Latency: a pattern first presented before edge k reaches samp at edge k. It is enqueued at edge k+STABLE_CYCLES. If the FIFO was empty, char_valid is high after that edge. Total latency is STABLE_CYCLES+1 edges. There is no fall-through path.
- Decode table (hex pattern -> code). Any other nonzero pattern -> code 31.
  - Digits: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9.
  - Letters: 77->10 (A), 7C->11 (b), 39->12 (C), 5E->13 (d), 79->14 (E), 71->15 (F), 3D->16 (G), 76->17 (H), 38->18 (L), 73->19 (P), 3E->20 (U), 6E->21 (y), 50->22 (r), 5C->23 (o).
  - Code 31 entries are enqueued normally.
- FIFO: circular buffer with read/write pointers one bit wider than the address.
  - A dequeue occurs on an edge where char_valid&char_ready.
  - Enqueue and dequeue in the same cycle: both take effect and fifo_level is unchanged.
  - When full, an enqueue with a simultaneous dequeue is accepted.
  - When full, an enqueue without a dequeue is dropped: overflow<=1 and char_count does not increment.
  - char_ready while empty has no effect.
- char_count increments on every accepted enqueue, modulo 256.
- overflow clears only on reset.

Optional Feature:
SEG7_READER_ACTIVE_LOW_EN.
- Defined: seg_in is treated as active-low (common-anode) and inverted before the sampler. The blank separator is therefore 7'h7F on the pins.
- Undefined: seg_in is used as-is, active-high.
- All other behaviour is identical.

Test Plan:
1. Reset; STABLE_CYCLES=4; hold seg_in=7'h3F for 10 cycles, char_ready=0 -> char_valid rises after edge 5 with char_code=0; exactly one entry (fifo_level=1, char_count=1).
2. Drive 06,00,06,00,5B, each held 6 cycles; then char_ready=1 -> dequeued codes 1,1,2 in order; blanks never appear.
3. Glitch: 3F for 3 cycles, then 00 -> nothing enqueued; fifo_level stays 0.
4. Five distinct characters with char_ready=0 and FIFO_DEPTH=4 -> fifo_level=4, overflow=1, char_count=4. Repeat the fifth character while dequeuing the head in the same cycle -> accepted, fifo_level stays 4.
5. Unknown pattern 7'h49 held 4 cycles -> code 31 enqueued. Assert rst_n=0 mid-run with 2 entries queued -> next cycle char_valid=0, fifo_level=0, overflow=0, char_count=0.
6. With SEG7_READER_ACTIVE_LOW_EN defined, drive ~7'h77=7'h08 for 4 cycles -> code 10 (A) enqueued.
